// File: rtl/composite_pipe_if.sv
// Valid/ready stream bundle carrying one flattened composite item.
// The master drives data/valid and the slave answers with ready.
interface composite_pipe_if #(
    parameter int DW = 24
);
    logic [DW-1:0] data;
    logic          valid;
    logic          ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/composite_pipe.sv
// Elastic multi-stage pipeline register for composite items (e.g. RGB pixels)
// with per-stage valid/ready, bubble collapsing, synchronous flush and occupancy count.
module composite_pipe #(
    parameter int               CHANNELS          = 3,
    parameter int               WIDTH             = 8,
    parameter int               DEPTH             = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE       = '0,
    parameter bit               FLUSH_CLEARS_DATA = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         i_flush,
    composite_pipe_if.slave              s_in,
    composite_pipe_if.master             m_out,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int DW = CHANNELS * WIDTH;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [DW-1:0] RESET_WORD = {CHANNELS{RESET_VALUE}};

    logic [DW-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [CW-1:0]    r_count;

    logic [DEPTH:0]   w_rdy;
    logic [DW-1:0]    w_prev_data [DEPTH];
    logic [DEPTH-1:0] w_prev_valid;
    logic             w_up;
    logic             w_dn;

    // A stage may load whenever it is empty or everything downstream of it moves;
    // this is what lets later items close up gaps left by idle input cycles.
    assign w_rdy[DEPTH] = m_out.ready;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            assign w_rdy[gi] = !r_valid[gi] || w_rdy[gi+1];
            if (gi == 0) begin : g_head
                assign w_prev_data[gi]  = s_in.data;
                assign w_prev_valid[gi] = s_in.valid;
            end else begin : g_body
                assign w_prev_data[gi]  = r_data[gi-1];
                assign w_prev_valid[gi] = r_valid[gi-1];
            end
        end
    endgenerate

    assign s_in.ready  = w_rdy[0] && !i_flush;
    assign m_out.valid = r_valid[DEPTH-1];
    assign m_out.data  = r_data[DEPTH-1];
    assign o_count     = r_count;

    assign w_up = s_in.valid && s_in.ready;
    assign w_dn = r_valid[DEPTH-1] && m_out.ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= RESET_WORD;
            end
            r_valid <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            // Data is kept unless the instance asks for scrubbed registers on flush.
            r_valid <= '0;
            r_count <= '0;
            if (FLUSH_CLEARS_DATA) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_data[i] <= RESET_WORD;
                end
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_rdy[i]) begin
                    r_data[i]  <= w_prev_data[i];
                    r_valid[i] <= w_prev_valid[i];
                end
            end
            if (w_up && !w_dn) begin
                r_count <= r_count + CW'(1);
            end else if (!w_up && w_dn) begin
                r_count <= r_count - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_composite_pipe.sv
// Drives three composite_pipe configurations with shared stimulus and checks each
// against an item-list reference model plus hand-derived vectors.
module tb_composite_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] tb_in_data = '0;
    logic        tb_in_valid = 1'b0;
    logic        tb_out_ready = 1'b0;
    logic        tb_flush = 1'b0;

    composite_pipe_if #(.DW(24)) a_in ();
    composite_pipe_if #(.DW(24)) a_out ();
    composite_pipe_if #(.DW(24)) b_in ();
    composite_pipe_if #(.DW(24)) b_out ();
    composite_pipe_if #(.DW(40)) c_in ();
    composite_pipe_if #(.DW(40)) c_out ();

    logic [1:0] cnt_a;
    logic [2:0] cnt_b;
    logic       cnt_c;

    assign a_in.data = tb_in_data[23:0];
    assign b_in.data = tb_in_data[23:0];
    assign c_in.data = tb_in_data[39:0];
    assign a_in.valid = tb_in_valid;
    assign b_in.valid = tb_in_valid;
    assign c_in.valid = tb_in_valid;
    assign a_out.ready = tb_out_ready;
    assign b_out.ready = tb_out_ready;
    assign c_out.ready = tb_out_ready;

    composite_pipe #(.CHANNELS(3), .WIDTH(8), .DEPTH(2)) u_a (
        .clk(clk), .reset_n(rst_n), .i_flush(tb_flush),
        .s_in(a_in), .m_out(a_out), .o_count(cnt_a));

    composite_pipe #(.CHANNELS(3), .WIDTH(8), .DEPTH(4), .RESET_VALUE(8'h5A),
                     .FLUSH_CLEARS_DATA(1'b1)) u_b (
        .clk(clk), .reset_n(rst_n), .i_flush(tb_flush),
        .s_in(b_in), .m_out(b_out), .o_count(cnt_b));

    composite_pipe #(.CHANNELS(4), .WIDTH(10), .DEPTH(1)) u_c (
        .clk(clk), .reset_n(rst_n), .i_flush(tb_flush),
        .s_in(c_in), .m_out(c_out), .o_count(cnt_c));

    logic        got_ir [3];
    logic        got_ov [3];
    logic [63:0] got_od [3];
    logic [3:0]  got_cnt [3];

    assign got_ir[0] = a_in.ready;
    assign got_ir[1] = b_in.ready;
    assign got_ir[2] = c_in.ready;
    assign got_ov[0] = a_out.valid;
    assign got_ov[1] = b_out.valid;
    assign got_ov[2] = c_out.valid;
    assign got_od[0] = 64'(a_out.data);
    assign got_od[1] = 64'(b_out.data);
    assign got_od[2] = 64'(c_out.data);
    assign got_cnt[0] = 4'(cnt_a);
    assign got_cnt[1] = 4'(cnt_b);
    assign got_cnt[2] = 4'(cnt_c);

    int n_tests = 0;
    int n_fail = 0;

    // Reference: per pipe, an ordered list of items (oldest first) with their stage index.
    logic [63:0] mdata [3][16];
    int          mpos  [3][16];
    int          mn    [3] = '{0, 0, 0};

    function automatic int dep(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 4 : 1);
    endfunction

    function automatic logic [63:0] mask(input int d);
        return (d == 2) ? 64'hFF_FFFF_FFFF : 64'hFF_FFFF;
    endfunction

    function automatic logic [63:0] rstword(input int d);
        return (d == 1) ? 64'h5A5A5A : 64'h0;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 3; d++) begin
            int   dd;
            logic e_ir;
            logic e_ov;
            dd   = dep(d);
            e_ir = (mn[d] < dd || tb_out_ready) && !tb_flush;
            e_ov = (mn[d] > 0) && (mpos[d][0] == dd - 1);
            check($sformatf("in_ready[%0d]", d), 64'(got_ir[d]), 64'(e_ir));
            check($sformatf("out_valid[%0d]", d), 64'(got_ov[d]), 64'(e_ov));
            check($sformatf("count[%0d]", d), 64'(got_cnt[d]), 64'(mn[d]));
            if (e_ov) check($sformatf("out_data[%0d]", d), got_od[d], mdata[d][0]);
        end
    endtask

    // Items advance when the slot ahead is free or its occupant advances;
    // the oldest item leaves past the last stage only when out_ready is high.
    task automatic model_edge();
        for (int d = 0; d < 3; d++) begin
            int   dd;
            int   prev_old;
            bit   prev_mv;
            bit   acc;
            dd       = dep(d);
            acc      = tb_in_valid && (mn[d] < dd || tb_out_ready) && !tb_flush;
            prev_old = dd;
            prev_mv  = tb_out_ready;
            for (int k = 0; k < mn[d]; k++) begin
                int old;
                bit mv;
                old = mpos[d][k];
                mv  = (old + 1 < prev_old) || prev_mv;
                if (mv) mpos[d][k] = old + 1;
                prev_old = old;
                prev_mv  = mv;
            end
            if (mn[d] > 0 && mpos[d][0] == dd) begin
                for (int k = 0; k < mn[d] - 1; k++) begin
                    mdata[d][k] = mdata[d][k+1];
                    mpos[d][k]  = mpos[d][k+1];
                end
                mn[d]--;
            end
            if (tb_flush) begin
                mn[d] = 0;
            end else if (acc) begin
                mdata[d][mn[d]] = tb_in_data & mask(d);
                mpos[d][mn[d]]  = 0;
                mn[d]++;
            end
        end
    endtask

    task automatic settle(input logic [63:0] din, input logic v, input logic ordy, input logic fl);
        @(negedge clk);
        tb_in_data   = din;
        tb_in_valid  = v;
        tb_out_ready = ordy;
        tb_flush     = fl;
        #1;
        check_all();
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
    endtask

    task automatic cycle(input logic [63:0] din, input logic v, input logic ordy, input logic fl);
        settle(din, v, ordy, fl);
        tick();
    endtask

    typedef struct {
        logic [63:0] din;
        logic        vin;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [23:0] e_od;
        int          e_cnt;
    } vec_t;

    vec_t tbl [13];

    initial begin
        logic [39:0] item40;
        logic [63:0] tmp;

        // Hand-derived expectations for the DEPTH=2 pipe: streaming, then backpressure.
        tbl[0]  = '{64'h102030, 1'b1, 1'b1, 1'b1, 1'b0, 24'h0,      0};
        tbl[1]  = '{64'h405060, 1'b1, 1'b1, 1'b1, 1'b0, 24'h0,      1};
        tbl[2]  = '{64'h708090, 1'b1, 1'b1, 1'b1, 1'b1, 24'h102030, 2};
        tbl[3]  = '{64'h0,      1'b0, 1'b1, 1'b1, 1'b1, 24'h405060, 2};
        tbl[4]  = '{64'h0,      1'b0, 1'b1, 1'b1, 1'b1, 24'h708090, 1};
        tbl[5]  = '{64'h0,      1'b0, 1'b1, 1'b1, 1'b0, 24'h0,      0};
        tbl[6]  = '{64'h112233, 1'b1, 1'b0, 1'b1, 1'b0, 24'h0,      0};
        tbl[7]  = '{64'h445566, 1'b1, 1'b0, 1'b1, 1'b0, 24'h0,      1};
        tbl[8]  = '{64'h778899, 1'b1, 1'b0, 1'b0, 1'b1, 24'h112233, 2};
        tbl[9]  = '{64'h778899, 1'b1, 1'b1, 1'b1, 1'b1, 24'h112233, 2};
        tbl[10] = '{64'h0,      1'b0, 1'b1, 1'b1, 1'b1, 24'h445566, 2};
        tbl[11] = '{64'h0,      1'b0, 1'b1, 1'b1, 1'b1, 24'h778899, 1};
        tbl[12] = '{64'h0,      1'b0, 1'b1, 1'b1, 1'b0, 24'h0,      0};

        #12;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset_out_valid[%0d]", d), 64'(got_ov[d]), 64'(0));
            check($sformatf("reset_count[%0d]", d), 64'(got_cnt[d]), 64'(0));
            check($sformatf("reset_out_data[%0d]", d), got_od[d], rstword(d));
        end
        #10;
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            settle(tbl[i].din, tbl[i].vin, tbl[i].ordy, 1'b0);
            check($sformatf("row%0d_in_ready", i), 64'(got_ir[0]), 64'(tbl[i].e_ir));
            check($sformatf("row%0d_out_valid", i), 64'(got_ov[0]), 64'(tbl[i].e_ov));
            check($sformatf("row%0d_count", i), 64'(got_cnt[0]), 64'(tbl[i].e_cnt));
            if (tbl[i].e_ov) check($sformatf("row%0d_out_data", i), got_od[0], 64'(tbl[i].e_od));
            $display("[TB] row %0d in=%06h v=%0d ordy=%0d -> ir=%0d ov=%0d od=%06h cnt=%0d",
                     i, tbl[i].din[23:0], tbl[i].vin, tbl[i].ordy, got_ir[0], got_ov[0],
                     got_od[0][23:0], got_cnt[0]);
            tick();
        end
        for (int i = 0; i < 6; i++) cycle(64'h0, 1'b0, 1'b1, 1'b0);

        // Bubble collapse in the DEPTH=4 pipe: A, idle, idle, B while stalled.
        cycle(64'hAAAAAA, 1'b1, 1'b0, 1'b0);
        cycle(64'h0, 1'b0, 1'b0, 1'b0);
        cycle(64'h0, 1'b0, 1'b0, 1'b0);
        cycle(64'hBBBBBB, 1'b1, 1'b0, 1'b0);
        cycle(64'h0, 1'b0, 1'b0, 1'b0);
        cycle(64'h0, 1'b0, 1'b0, 1'b0);
        settle(64'h0, 1'b0, 1'b0, 1'b0);
        check("bubble_count", 64'(got_cnt[1]), 64'd2);
        check("bubble_in_ready", 64'(got_ir[1]), 64'd1);
        check("bubble_out_data", got_od[1], 64'hAAAAAA);
        $display("[TB] bubble collapse: cnt=%0d ir=%0d od=%06h", got_cnt[1], got_ir[1], got_od[1][23:0]);
        tick();

        // Flush with three items held and a competing input item.
        cycle(64'hCCCCCC, 1'b1, 1'b0, 1'b0);
        settle(64'hDDDDDD, 1'b1, 1'b0, 1'b1);
        check("flush_in_ready", 64'(got_ir[1]), 64'd0);
        check("flush_pre_count", 64'(got_cnt[1]), 64'd3);
        tick();
        settle(64'h0, 1'b0, 1'b0, 1'b0);
        check("flush_count", 64'(got_cnt[1]), 64'd0);
        check("flush_out_valid", 64'(got_ov[1]), 64'd0);
        check("flush_out_data", got_od[1], 64'h5A5A5A);
        $display("[TB] flush: cnt=%0d ov=%0d od=%06h", got_cnt[1], got_ov[1], got_od[1][23:0]);
        tick();

        // Four 10-bit fields through the single-stage pipe.
        item40 = {10'h3FF, 10'h000, 10'h155, 10'h2AA};
        cycle(64'(item40), 1'b1, 1'b1, 1'b0);
        settle(64'h12345, 1'b1, 1'b1, 1'b0);
        tmp = got_od[2];
        check("d1_out_valid", 64'(got_ov[2]), 64'd1);
        check("d1_out_data", tmp, 64'(item40));
        check("d1_field0", 64'(tmp[9:0]), 64'h2AA);
        check("d1_field3", 64'(tmp[39:30]), 64'h3FF);
        check("d1_full_pass_ready", 64'(got_ir[2]), 64'd1);
        $display("[TB] depth1: ov=%0d od=%010h ir=%0d", got_ov[2], tmp[39:0], got_ir[2]);
        tick();
        for (int i = 0; i < 4; i++) cycle({$urandom, $urandom}, 1'b1, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a cycle with items in flight.
        cycle(64'h0, 1'b0, 1'b0, 1'b0);
        check("pre_reset_out_valid", 64'(got_ov[0]), 64'd1);
        tb_in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("async_out_valid[%0d]", d), 64'(got_ov[d]), 64'd0);
            check($sformatf("async_count[%0d]", d), 64'(got_cnt[d]), 64'd0);
            check($sformatf("async_out_data[%0d]", d), got_od[d], rstword(d));
            mn[d] = 0;
        end
        $display("[TB] async reset: ov=%0d cnt=%0d", got_ov[0], got_cnt[0]);
        #4;
        rst_n = 1'b1;

        // Randomised traffic with phases of light and heavy backpressure.
        for (int i = 0; i < 600; i++) begin
            logic v;
            logic r;
            logic f;
            v = ($urandom_range(0, 3) != 0);
            r = (i % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 40) == 0);
            cycle({$urandom, $urandom}, v, r, f);
        end
        settle(64'h0, 1'b0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/composite_pipe.md
Name: composite_pipe

Overview:
- Parametrised elastic pipeline register for composite (multi-field) data such as RGB pixels: CHANNELS fields of WIDTH bits each, carried through DEPTH registered stages.
- Supersedes the fixed 3x8-bit plain struct registers. Adds a valid/ready handshake per stage, bubble collapsing, synchronous flush, a configurable reset value and an occupancy count.
- Sits between pixel producers and consumers in the video datapath.

Parameters:
- CHANNELS, 3, number of fields per item; field 0 occupies the LSBs of the flattened bus (field 0 = b, 1 = g, 2 = r for RGB).
- WIDTH, 8, bits per field.
- DEPTH, 2, number of register stages; legal range 1..16.
- RESET_VALUE, 0, value loaded into every field of every stage's data register at reset.
- FLUSH_CLEARS_DATA, 0, when 1 a flush also loads RESET_VALUE into all data registers; when 0 only the valid bits clear.

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of all stages.
- in_data  input  CHANNELS*WIDTH  upstream item.
- in_valid  input  1  upstream item present.
- in_ready  output  1  pipe accepts in_data this cycle.
- out_data  output  CHANNELS*WIDTH  data of last stage.
- out_valid  output  1  last stage holds an item.
- out_ready  input  1  downstream accepts out_data.
- count  output  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- Stage i (0..DEPTH-1) holds a data register d[i] and a valid bit v[i]. Stage 0 is the input side; stage DEPTH-1 drives out_data and out_valid.
- Reset (reset_n low, async):
  - all v[i]=0 and count=0.
  - every field of every d[i] = RESET_VALUE[WIDTH-1:0], so out_data = RESET_VALUE replicated CHANNELS times.
  - out_valid=0; in_ready=1 after reset deasserts.
- Advance rule (combinational ready chain, no extra latency):
  - rdy[DEPTH-1] = !v[DEPTH-1] || out_ready.
  - rdy[i] = !v[i] || (v[i+1]==0 || rdy[i+1]), i.e. rdy[i] = !v[i] || rdy[i+1], which collapses bubbles.
  - in_ready = rdy[0] && !flush.
- Stage update on each rising edge when rdy[i]:
  - stage 0: d[0] <= in_data and v[0] <= in_valid.
  - stage i>0: d[i] <= d[i-1] and v[i] <= v[i-1].
  - When rdy[i]=0 the stage holds.
  - Data registers load even when the incoming valid is 0; the content is don't-care but must be deterministic.
- Latency: with no stalls, an item accepted at edge t is on out_data with out_valid=1 after edge t+DEPTH-1, i.e. DEPTH cycles from presentation. Throughput is one item per cycle.
- Transfers:
  - Upstream transfer occurs only when in_valid && in_ready.
  - Downstream transfer occurs only when out_valid && out_ready.
  - out_data and out_valid stay stable while out_valid && !out_ready.
- Full and empty:
  - Full: all v=1 and out_ready=0 gives in_ready=0.
  - Empty: out_valid=0; out_ready is ignored.
  - When full and out_ready=1, in_ready=1 in the same cycle (pass-through, no bubble).
- Flush:
  - On an edge with flush=1, all v[i] <= 0 and count <= 0.
  - Data registers are loaded with RESET_VALUE only if FLUSH_CLEARS_DATA=1.
  - Flush overrides a simultaneous in_valid: the item is not accepted, since in_ready=0.
  - A simultaneous out_valid && out_ready is still a completed downstream transfer in that cycle.
- count:
  - Registered; equals popcount of v after each edge.
  - +1 on upstream transfer, -1 on downstream transfer, unchanged when both happen in the same cycle.
  - Forced to 0 by reset or flush.
- DEPTH=1 degenerates to a single register with a combinational ready path (in_ready = !v[0] || out_ready).
- Reset asserted mid-stream discards all items immediately and asynchronously; there is no partial output.

Test Plan:
1. Streaming, DEPTH=2, out_ready=1: present 0x102030, 0x405060, 0x708090 on consecutive cycles -> out_valid rises 2 cycles after the first item; outputs appear in the same order on consecutive cycles; count peaks at 2.
2. Backpressure: fill with 0x112233, 0x445566 while out_ready=0 -> count=2, in_ready=0, out_data holds 0x112233. Raise out_ready -> in_ready=1 in the same cycle; items drain in order with no bubble.
3. Bubble collapse, DEPTH=4: send A, idle, idle, B with out_ready=0 -> both items pack into stages 3 and 2, count=2, in_ready=1 (two free stages remain).
4. Flush with in_valid=1 and pipe holding 3 items -> in_ready=0 that cycle; next cycle count=0, out_valid=0. With FLUSH_CLEARS_DATA=1 and RESET_VALUE=8'h5A, out_data=0x5A5A5A.
5. Async reset: assert reset_n low mid-cycle while out_valid=1 -> out_valid=0 and count=0 immediately, before the next edge; out_data=RESET_VALUE in every field.
6. Generality: CHANNELS=4, WIDTH=10, DEPTH=1 -> item 0x3FF_000_155_2AA passes with 1-cycle latency; field order is preserved (field 0 in LSBs); full-with-out_ready=1 accepts a new item every cycle.
